// File: rtl/prim_clock_gate_ctrl_pkg.sv
// Shared types for the clock-gate controller: FSM state encoding and counter width.
package prim_clock_gate_ctrl_pkg;

    localparam int CtrlCntW = 8;

    typedef enum logic [1:0] {
        StRun   = 2'b00,
        StIdle  = 2'b01,
        StGated = 2'b10,
        StWake  = 2'b11
    } cg_state_e;

    // The gated domain is usable only while the clock runs and has settled.
    function automatic logic cg_is_ready(input cg_state_e st);
        return (st == StRun) || (st == StIdle);
    endfunction

endpackage

// File: rtl/prim_clock_gate_ctrl.sv
// Idle-detecting clock-gate controller: gates after a run of idle cycles and
// re-enables with a settle window on activity, wake request or loss of permission.
module prim_clock_gate_ctrl
    import prim_clock_gate_ctrl_pkg::*;
#(
    parameter int IdleCycles = 16,
    parameter int WakeCycles = 2,
    parameter int GateCntW   = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                sleep_en_i,
    input  logic                busy_i,
    input  logic                wake_req_i,
    output logic                en_o,
    output logic                ready_o,
    output logic                gated_o,
    output logic [GateCntW-1:0] gate_cnt_o
);

    localparam logic [CtrlCntW-1:0] IdleLast = CtrlCntW'(IdleCycles - 1);
    localparam logic [CtrlCntW-1:0] WakeLast = CtrlCntW'(WakeCycles - 1);

    cg_state_e              state_q;
    cg_state_e              state_d;
    logic [CtrlCntW-1:0]    cnt_q;
    logic [CtrlCntW-1:0]    cnt_d;
    logic [GateCntW-1:0]    gate_cnt_q;
    logic                   gate_evt;
    logic                   idle_cond;
    logic                   en_q;
    logic                   ready_q;
    logic                   gated_q;

    // A pending wake request always vetoes idleness, so RUN holds under wake.
    assign idle_cond = sleep_en_i & ~busy_i & ~wake_req_i;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gate_evt = 1'b0;
        case (state_q)
            StRun: begin
                if (idle_cond) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            StIdle: begin
                if (!idle_cond) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else if (cnt_q == IdleLast) begin
                    state_d  = StGated;
                    gate_evt = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StGated: begin
                if (busy_i || wake_req_i || !sleep_en_i) begin
                    state_d = StWake;
                    cnt_d   = '0;
                end
            end
            StWake: begin
                if (cnt_q == WakeLast) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = StRun;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StRun;
            cnt_q      <= '0;
            gate_cnt_q <= '0;
            en_q       <= 1'b1;
            ready_q    <= 1'b1;
            gated_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= (state_d != StGated);
            ready_q <= cg_is_ready(state_d);
            gated_q <= (state_d == StGated);
            if (gate_evt && (gate_cnt_q != '1)) begin
                gate_cnt_q <= gate_cnt_q + 1'b1;
            end
        end
    end

    assign en_o       = en_q;
    assign ready_o    = ready_q;
    assign gated_o    = gated_q;
    assign gate_cnt_o = gate_cnt_q;

endmodule

// File: tb/tb_prim_clock_gate_ctrl.sv
// Directed bench for the clock-gate controller (IdleCycles=4, WakeCycles=2),
// with a second instance using a 2-bit gating-event counter.
module tb_prim_clock_gate_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        sleep_en;
    logic        busy;
    logic        wake_req;
    logic        en;
    logic        ready;
    logic        gated;
    logic [15:0] gate_cnt;
    logic        en2;
    logic        ready2;
    logic        gated2;
    logic [1:0]  gate_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prim_clock_gate_ctrl #(.IdleCycles(4), .WakeCycles(2), .GateCntW(16)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .sleep_en_i (sleep_en),
        .busy_i     (busy),
        .wake_req_i (wake_req),
        .en_o       (en),
        .ready_o    (ready),
        .gated_o    (gated),
        .gate_cnt_o (gate_cnt)
    );

    prim_clock_gate_ctrl #(.IdleCycles(4), .WakeCycles(2), .GateCntW(2)) dut_sat (
        .clk_i      (clk),
        .rst_i      (rst),
        .sleep_en_i (sleep_en),
        .busy_i     (busy),
        .wake_req_i (wake_req),
        .en_o       (en2),
        .ready_o    (ready2),
        .gated_o    (gated2),
        .gate_cnt_o (gate_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n clock edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; sleep_en = 1'b0; busy = 1'b1; wake_req = 1'b0;
        step(2);
        chk("rst_en", en, 1);
        chk("rst_ready", ready, 1);
        chk("rst_gated", gated, 0);
        chk("rst_cnt", gate_cnt, 0);
        chk("rst_cnt2", gate_cnt2, 0);

        // Busy falls with permission: IDLE after 1 edge, GATED after 5.
        rst = 1'b0; sleep_en = 1'b1; busy = 1'b0;
        step(1);
        chk("idle_ready", ready, 1);
        chk("idle_gated", gated, 0);
        step(3);
        chk("pregate_en", en, 1);
        step(1);
        chk("gate_en", en, 0);
        chk("gate_gated", gated, 1);
        chk("gate_ready", ready, 0);
        chk("gate_cnt1", gate_cnt, 1);

        // Wake request pulse while gated: 2-cycle settle window.
        wake_req = 1'b1;
        step(1);
        wake_req = 1'b0; busy = 1'b1;
        chk("wake_en", en, 1);
        chk("wake_gated", gated, 0);
        chk("wake_ready0", ready, 0);
        step(1);
        chk("wake_ready1", ready, 0);
        chk("wake_en1", en, 1);
        step(1);
        chk("wake_ready2", ready, 1);
        chk("wake_cnt", gate_cnt, 1);

        // Busy pulse in IDLE (counter=1) restarts the idle run.
        busy = 1'b0;
        step(2);
        busy = 1'b1;
        step(1);
        busy = 1'b0;
        chk("pulse_en3", en, 1);
        for (int i = 4; i <= 7; i++) begin
            step(1);
            chk($sformatf("pulse_en%0d", i), en, 1);
        end
        step(1);
        chk("pulse_gate_en", en, 0);
        chk("pulse_gate_cnt", gate_cnt, 2);

        // Reset while gated returns straight to a ready, running state.
        rst = 1'b1; sleep_en = 1'b0;
        step(1);
        rst = 1'b0;
        chk("gr_en", en, 1);
        chk("gr_ready", ready, 1);
        chk("gr_gated", gated, 0);
        chk("gr_cnt", gate_cnt, 0);
        chk("gr_cnt2", gate_cnt2, 0);

        // Permission withdrawn while gated, then held off for 100 cycles.
        sleep_en = 1'b1; busy = 1'b0;
        step(5);
        chk("sl_gated", gated, 1);
        chk("sl_cnt2", gate_cnt2, 1);
        sleep_en = 1'b0;
        step(1);
        chk("sl_wake_gated", gated, 0);
        chk("sl_wake_ready", ready, 0);
        step(1);
        chk("sl_wake_ready1", ready, 0);
        step(1);
        chk("sl_run_ready", ready, 1);
        for (int i = 0; i < 100; i++) begin
            step(1);
            chk("sl_hold_en", en, 1);
        end
        chk("sl_hold_ready", ready, 1);

        // Six more gate/wake rounds: 2-bit counter saturates at 3.
        for (int k = 2; k <= 7; k++) begin
            sleep_en = 1'b1; busy = 1'b0;
            step(5);
            chk($sformatf("sat_gated%0d", k), gated2, 1);
            chk($sformatf("sat_cnt2_%0d", k), gate_cnt2, (k > 3) ? 3 : k);
            chk($sformatf("sat_cnt_%0d", k), gate_cnt, k);
            busy = 1'b1;
            step(3);
            chk($sformatf("sat_ready%0d", k), ready2, 1);
        end

        // Held wake request vetoes idleness; clearing it lets gating proceed.
        sleep_en = 1'b1; busy = 1'b0; wake_req = 1'b1;
        step(8);
        chk("wr_en", en, 1);
        chk("wr_gated", gated, 0);
        wake_req = 1'b0;
        step(4);
        chk("wr_pre_en", en, 1);
        step(1);
        chk("wr_gated_after", gated, 1);
        chk("wr_cnt", gate_cnt, 8);
        chk("wr_cnt2", gate_cnt2, 3);
        busy = 1'b1;
        step(1);
        chk("busy_exit_gated", gated, 0);
        chk("busy_exit_ready", ready, 0);
        chk("busy_exit_en", en, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
